// File: rtl/poly_operand_driver.sv
// poly_operand_driver: automatic operand sequencer and result checker for the polynomial evaluator
// Ports:
//   clk, resetn          clock and synchronous active-low reset (shared with the evaluator)
//   start                one-cycle request, honoured only while busy=0
//   a_in/b_in/c_in/x_in  operands, captured on an accepted start
//   result_in            evaluator data_result
//   data_out, go         operand bus and go strobe towards the evaluator
//   busy, done           transaction in flight / one-cycle completion pulse
//   result, match        sampled result_in and its comparison with A*x^2+B*x+C, held until next done
module poly_operand_driver #(
    parameter int DATA_W      = 8,
    parameter int GO_HIGH_CYC = 2,
    parameter int GO_LOW_CYC  = 2,
    parameter int RESULT_WAIT = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] data_out,
    output logic              go,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              match
);
    localparam int MAX_HL = GO_HIGH_CYC > GO_LOW_CYC ? GO_HIGH_CYC : GO_LOW_CYC;
    localparam int MAX_C  = MAX_HL > RESULT_WAIT ? MAX_HL : RESULT_WAIT;
    localparam int CW     = $clog2(MAX_C + 1);
    typedef enum logic [2:0] {IDLE, SETUP, GO_HI, GO_LO, WAIT_RES, REPORT} state_t;
    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_load;
    logic [1:0]        idx;
    logic [DATA_W-1:0] ops [4];
    logic [DATA_W-1:0] ax, expected;
    // Every intermediate truncates to DATA_W, like the evaluator's ALU
    assign ax       = ops[0] * ops[3];
    assign expected = ax * ops[3] + ops[1] * ops[3] + ops[2];
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = start ? SETUP : IDLE;
            SETUP:    state_nxt = GO_HI;
            GO_HI:    state_nxt = cnt == '0 ? GO_LO : GO_HI;
            GO_LO:    state_nxt = cnt != '0 ? GO_LO : (idx == 2'd3 ? WAIT_RES : SETUP);
            WAIT_RES: state_nxt = cnt == '0 ? REPORT : WAIT_RES;
            REPORT:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // Counter is reloaded on every state entry, so it counts down to 0 and never wraps
        cnt_load = state_nxt == GO_HI    ? CW'(GO_HIGH_CYC - 1) :
                   state_nxt == GO_LO    ? CW'(GO_LOW_CYC - 1)  :
                   state_nxt == WAIT_RES ? CW'(RESULT_WAIT - 1) : '0;
        go = state == GO_HI;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            ops      <= '{default: '0};
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            match    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? cnt_load : (cnt != '0 ? cnt - 1'b1 : cnt);
            done  <= state == WAIT_RES && cnt == '0;
            // data_out is loaded on SETUP entry so it is valid for the whole setup cycle
            if (state == IDLE && start) begin
                ops      <= '{a_in, b_in, c_in, x_in};
                idx      <= '0;
                data_out <= a_in;
                busy     <= 1'b1;
            end
            if (state == GO_LO && state_nxt == SETUP) begin
                idx      <= idx + 2'd1;
                data_out <= ops[idx + 2'd1];
            end
            if (state == WAIT_RES && cnt == '0) begin
                result <= result_in;
                match  <= result_in == expected;
            end
            if (state == REPORT)
                busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_poly_operand_driver.sv
// tb_poly_operand_driver: randomized self-checking bench for poly_operand_driver
module tb_poly_operand_driver;
    localparam int W       = 8;
    localparam int GH      = 2;
    localparam int GL      = 2;
    localparam int RW      = 7;
    localparam int TXN_CYC = 4 * (1 + GH + GL) + RW + 1;
    logic         clk = 1'b0;
    logic         resetn, start, go, busy, done, match;
    logic [W-1:0] a_in, b_in, c_in, x_in, result_in, data_out, result;
    logic [W-1:0] last_result;
    int           checks = 0;
    int           errors = 0;
    always #5 clk = ~clk;
    poly_operand_driver #(.DATA_W(W), .GO_HIGH_CYC(GH), .GO_LOW_CYC(GL), .RESULT_WAIT(RW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in),
        .result_in(result_in), .data_out(data_out), .go(go),
        .busy(busy), .done(done), .result(result), .match(match)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic scramble_inputs();
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        c_in = 8'($urandom);
        x_in = 8'($urandom);
    endtask
    // rin_mode: -1 evaluator returns the correct value, -2 a corrupted one, >=0 a fixed stub value.
    // restart_at: sample index at which a stray start is pulsed mid-sequence (0 = none).
    task automatic run_txn(input logic [7:0] a, b, c, x, input int rin_mode, input int restart_at);
        int          full, hi, lo, since_fall, dones, done_at;
        logic [7:0]  exp_v, rin, prev_d, pulse_v;
        logic [7:0]  want [4];
        logic [7:0]  seen [$];
        logic        prev_go;
        want[0] = a; want[1] = b; want[2] = c; want[3] = x;
        full  = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
        exp_v = 8'(full % 256);
        rin   = rin_mode >= 0 ? 8'(rin_mode) :
                rin_mode == -1 ? exp_v : exp_v ^ 8'($urandom_range(1, 255));
        hi = 0; lo = 0; since_fall = 99; dones = 0; done_at = -1;
        prev_go = 1'b0; pulse_v = '0; prev_d = data_out;
        a_in = a; b_in = b; c_in = c; x_in = x;
        result_in = rin;
        start = 1'b1;
        for (int n = 1; n <= TXN_CYC + 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
                chk("result_held", result, last_result);
            end
            if (n == restart_at) begin
                scramble_inputs();
                start = 1'b1;
            end
            if (n == restart_at + 1) start = 1'b0;
            if (go && !prev_go) begin
                if (seen.size() > 0) chk("go_low_len", lo, GL + 1);
                chk("setup_stable", data_out, prev_d);
                seen.push_back(data_out);
                pulse_v = data_out;
                hi = 0;
            end
            if (go) begin
                hi++;
                chk("hold_high", data_out, pulse_v);
            end
            if (!go && prev_go) begin
                chk("go_high_len", hi, GH);
                lo = 0;
                since_fall = 0;
            end
            if (!go) begin
                lo++;
                if (since_fall < GL) chk("hold_low", data_out, pulse_v);
                since_fall++;
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_at = n;
                    chk("done_cycle", n, TXN_CYC);
                    chk("result", result, rin);
                    chk("match", match, rin == exp_v);
                    chk("pulse_count", seen.size(), 4);
                    for (int i = 0; i < seen.size() && i < 4; i++) chk("operand", seen[i], want[i]);
                    scramble_inputs();
                    start = 1'b1;
                end
            end
            if (dones > 0 && n == done_at + 1) begin
                chk("done_pulse", done, 0);
                chk("start_in_done_ignored", busy, 0);
                start = 1'b0;
            end
            prev_go = go;
            prev_d  = data_out;
            if (dones > 0 && n == done_at + 4) break;
        end
        start = 1'b0;
        chk("done_count", dones, 1);
        last_result = rin;
    endtask
    task automatic reset_mid();
        int   rises, dones;
        logic pg;
        rises = 0; dones = 0; pg = 1'b0;
        scramble_inputs();
        result_in = 8'($urandom);
        start = 1'b1;
        for (int n = 1; n <= 40 && rises < 2; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (go && !pg) rises++;
            pg = go;
        end
        chk("reached_b_go_hi", rises, 2);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_match", match, 0);
        resetn = 1'b1;
        for (int n = 0; n < TXN_CYC + 5; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        last_result = '0;
    endtask
    initial begin
        resetn = 1'b0; start = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; x_in = '0; result_in = '0;
        last_result = '0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", data_out, 0);
        chk("reset_go", go, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_match", match, 0);
        resetn = 1'b1;
        @(negedge clk);
        run_txn(8'd1, 8'd2, 8'd3, 8'd4, -1, 0);
        chk("vec1_result", result, 8'h1B);
        chk("vec1_match", match, 1);
        run_txn(8'd3, 8'd5, 8'd7, 8'd10, -1, 0);
        chk("vec2_result", result, 8'h65);
        chk("vec2_match", match, 1);
        run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, 9);
        reset_mid();
        run_txn(8'd9, 8'd8, 8'd7, 8'd6, -1, 0);
        run_txn(8'd1, 8'd1, 8'd1, 8'd1, 0, 0);
        chk("stub_result", result, 8'h00);
        chk("stub_match", match, 0);
        for (int t = 0; t < 12; t++)
            run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 1) == 0 ? -1 : -2,
                    $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(2, 25)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
